// File: rtl/ca_code_player.sv
`default_nettype none
// ============================================================================
// Module      : ca_code_player
// Description : Captures a WORDS x 32-bit C/A code burst from the packet cache
//               into a ping-pong buffer and replays it continuously as a chip
//               stream plus a signed DAC sample. A new code replaces the old
//               one only at a code-epoch boundary.
// Revision    : 1.0 - initial release
// ============================================================================
module ca_code_player #(
   parameter int WORDS = 32,
   parameter int DAC_W = 14,
   parameter int DIV_W = 16
) (
   input  logic             rdclock,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [31:0]      wr_data,
   input  logic [DIV_W-1:0] chip_div,
   input  logic [DAC_W-2:0] amplitude,
   input  logic             play_en,
   output logic             chip,
   output logic             chip_strobe,
   output logic             epoch,
   output logic [DAC_W-1:0] dac_data,
   output logic             bank_valid,
   output logic             swap_pending,
   output logic             load_err
);

   localparam int CHIPS  = WORDS * 32;
   localparam int CIDX_W = $clog2(CHIPS);
   localparam int WIDX_W = $clog2(WORDS);
   localparam int WCNT_W = $clog2(WORDS + 1);

   typedef enum logic [0:0] { L_IDLE = 1'b0, L_LOAD = 1'b1 } load_state_t;
   typedef enum logic [0:0] { P_STOP = 1'b0, P_RUN  = 1'b1 } play_state_t;

   // Loader / bank management
   load_state_t       lstate_q, lstate_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic              ovl_q, ovl_d;
   logic              err_q, err_d;
   logic              pend_q, pend_d;
   logic              valid_q, valid_d;
   logic              sel_q, sel_d;       // 0: bank0 active, 1: bank1 active
   logic              mem_we;
   logic [WIDX_W-1:0] mem_addr;
   logic              load_done;
   logic              wrap;
   logic              commit;

   // Player
   play_state_t       pstate_q, pstate_d;
   logic [CIDX_W-1:0] cidx_q, cidx_d;
   logic [DIV_W-1:0]  dcnt_q, dcnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              chip_q, chip_d;
   logic              strb_q, strb_d;
   logic              epoch_q, epoch_d;
   logic [DAC_W-1:0]  dac_q, dac_d;
   logic              present;
   logic [31:0]       fetch_word;
   logic              fetch_bit;
   logic [DAC_W-1:0]  dac_pos;

   logic [31:0] bank0_q [WORDS];
   logic [31:0] bank1_q [WORDS];

   assign dac_pos = {1'b0, amplitude};

   // Loader next-state: collects a burst into the shadow bank and judges its length
   always_comb begin
      lstate_d  = lstate_q;
      wcnt_d    = wcnt_q;
      ovl_d     = ovl_q;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      load_done = 1'b0;
      case (lstate_q)
         L_IDLE: begin
            if (wr_en) begin
               lstate_d = L_LOAD;
               mem_we   = 1'b1;
               mem_addr = '0;
               wcnt_d   = WCNT_W'(1);
               ovl_d    = 1'b0;
            end
         end
         L_LOAD: begin
            if (wr_en) begin
               if (wcnt_q < WCNT_W'(WORDS)) begin
                  mem_we   = 1'b1;
                  mem_addr = wcnt_q[WIDX_W-1:0];
                  wcnt_d   = wcnt_q + WCNT_W'(1);
               end else begin
                  ovl_d = 1'b1;
               end
            end else begin
               lstate_d = L_IDLE;
               if ((wcnt_q == WCNT_W'(WORDS)) && !ovl_q) begin
                  load_done = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         default: lstate_d = L_IDLE;
      endcase
   end

   // Commit decision: swap immediately when idle, otherwise only at the code wrap.
   // Never while a burst is being written, so the shadow bank is always whole.
   always_comb begin
      wrap    = (pstate_q == P_RUN) && (dcnt_q == div_q) &&
                (cidx_q == CIDX_W'(CHIPS - 1));
      commit  = pend_q && (lstate_q == L_IDLE) && !wr_en &&
                ((pstate_q == P_STOP) || !valid_q || wrap);
      pend_d  = commit ? 1'b0 : (load_done ? 1'b1 : pend_q);
      valid_d = valid_q | commit;
      sel_d   = sel_q ^ commit;
   end

   // Player next-state: chip divider, chip index and registered chip/DAC values
   always_comb begin
      pstate_d = pstate_q;
      cidx_d   = cidx_q;
      dcnt_d   = dcnt_q;
      div_d    = div_q;
      chip_d   = chip_q;
      dac_d    = dac_q;
      strb_d   = 1'b0;
      epoch_d  = 1'b0;
      present  = 1'b0;
      case (pstate_q)
         P_STOP: begin
            if (play_en && valid_q) begin
               pstate_d = P_RUN;
               cidx_d   = '0;
               dcnt_d   = '0;
               present  = 1'b1;
            end
         end
         P_RUN: begin
            if (!play_en) begin
               pstate_d = P_STOP;
               cidx_d   = '0;
               dcnt_d   = '0;
               chip_d   = 1'b0;
               dac_d    = '0;
            end else if (dcnt_q == div_q) begin
               cidx_d  = (cidx_q == CIDX_W'(CHIPS - 1)) ? '0 : cidx_q + CIDX_W'(1);
               dcnt_d  = '0;
               present = 1'b1;
            end else begin
               dcnt_d = dcnt_q + DIV_W'(1);
            end
         end
         default: pstate_d = P_STOP;
      endcase
      // A commit in this cycle means the next chip already comes from the new bank
      fetch_word = (sel_q ^ commit) ? bank1_q[cidx_d[CIDX_W-1:5]]
                                    : bank0_q[cidx_d[CIDX_W-1:5]];
      fetch_bit  = fetch_word[~cidx_d[4:0]];
      if (present) begin
         div_d   = chip_div;
         chip_d  = fetch_bit;
         dac_d   = fetch_bit ? dac_pos : -dac_pos;
         strb_d  = 1'b1;
         epoch_d = (cidx_d == '0);
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge rdclock or negedge rst_n) begin
      if (!rst_n) begin
         lstate_q <= L_IDLE;
         wcnt_q   <= '0;
         ovl_q    <= 1'b0;
         err_q    <= 1'b0;
         pend_q   <= 1'b0;
         valid_q  <= 1'b0;
         sel_q    <= 1'b0;
         pstate_q <= P_STOP;
         cidx_q   <= '0;
         dcnt_q   <= '0;
         div_q    <= '0;
         chip_q   <= 1'b0;
         strb_q   <= 1'b0;
         epoch_q  <= 1'b0;
         dac_q    <= '0;
      end else begin
         lstate_q <= lstate_d;
         wcnt_q   <= wcnt_d;
         ovl_q    <= ovl_d;
         err_q    <= err_d;
         pend_q   <= pend_d;
         valid_q  <= valid_d;
         sel_q    <= sel_d;
         pstate_q <= pstate_d;
         cidx_q   <= cidx_d;
         dcnt_q   <= dcnt_d;
         div_q    <= div_d;
         chip_q   <= chip_d;
         strb_q   <= strb_d;
         epoch_q  <= epoch_d;
         dac_q    <= dac_d;
      end
   end

   // Code storage: bursts always land in the bank that is not being played
   always_ff @(posedge rdclock) begin
      if (mem_we) begin
         if (sel_q) begin
            bank0_q[mem_addr] <= wr_data;
         end else begin
            bank1_q[mem_addr] <= wr_data;
         end
      end
   end

   assign chip         = chip_q;
   assign chip_strobe  = strb_q;
   assign epoch        = epoch_q;
   assign dac_data     = dac_q;
   assign bank_valid   = valid_q;
   assign swap_pending = pend_q;
   assign load_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ca_code_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_ca_code_player
// Description : Self-checking bench for ca_code_player: behavioural model of
//               the code buffer and chip timeline, per-cycle comparison, and
//               directed literal checks of the documented scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ca_code_player;

   localparam int WORDS = 32;
   localparam int DAC_W = 14;
   localparam int DIV_W = 16;
   localparam int CHIPS = WORDS * 32;

   logic             rdclock   = 1'b0;
   logic             rst_n     = 1'b0;
   logic             wr_en     = 1'b0;
   logic [31:0]      wr_data   = '0;
   logic [DIV_W-1:0] chip_div  = '0;
   logic [DAC_W-2:0] amplitude = '0;
   logic             play_en   = 1'b0;
   logic             chip;
   logic             chip_strobe;
   logic             epoch;
   logic [DAC_W-1:0] dac_data;
   logic             bank_valid;
   logic             swap_pending;
   logic             load_err;

   int n_checks = 0;
   int n_fail   = 0;

   ca_code_player #(.WORDS(WORDS), .DAC_W(DAC_W), .DIV_W(DIV_W)) dut (
      .rdclock      (rdclock),
      .rst_n        (rst_n),
      .wr_en        (wr_en),
      .wr_data      (wr_data),
      .chip_div     (chip_div),
      .amplitude    (amplitude),
      .play_en      (play_en),
      .chip         (chip),
      .chip_strobe  (chip_strobe),
      .epoch        (epoch),
      .dac_data     (dac_data),
      .bank_valid   (bank_valid),
      .swap_pending (swap_pending),
      .load_err     (load_err)
   );

   always #5 rdclock = ~rdclock;

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit [31:0] m_act [WORDS];
   bit [31:0] m_shd [WORDS];
   bit        m_valid, m_pend, m_loading, m_run;
   int        m_cnt, m_chip, m_held, m_hold;
   bit        e_chip, e_strobe, e_epoch, e_err;
   int        e_dac;

   task automatic model_reset();
      m_valid = 0; m_pend = 0; m_loading = 0; m_run = 0;
      m_cnt = 0; m_chip = 0; m_held = 0; m_hold = 1;
      e_chip = 0; e_strobe = 0; e_epoch = 0; e_err = 0; e_dac = 0;
   endtask

   task automatic present_chip();
      m_hold   = int'(chip_div) + 1;
      m_held   = 1;
      e_chip   = m_act[m_chip / 32][31 - (m_chip % 32)];
      e_dac    = e_chip ? int'(amplitude) : -int'(amplitude);
      e_strobe = 1;
      e_epoch  = (m_chip == 0);
   endtask

   task automatic model_step();
      bit done, wrap, commit, was_loading, was_valid;
      done        = 0;
      e_err       = 0;
      e_strobe    = 0;
      e_epoch     = 0;
      was_loading = m_loading;
      was_valid   = m_valid;
      wrap   = m_run && (m_chip == CHIPS - 1) && (m_held == m_hold);
      commit = m_pend && !was_loading && !wr_en && (!m_run || !m_valid || wrap);
      if (wr_en) begin
         if (!m_loading) begin
            m_loading = 1;
            m_cnt     = 0;
         end
         if (m_cnt < WORDS) m_shd[m_cnt] = wr_data;
         m_cnt++;
      end else if (m_loading) begin
         m_loading = 0;
         if (m_cnt == WORDS) done = 1;
         else e_err = 1;
      end
      if (commit) begin
         m_act   = m_shd;
         m_valid = 1;
         m_pend  = 0;
      end
      if (done) m_pend = 1;
      if (!m_run) begin
         if (play_en && was_valid) begin
            m_run  = 1;
            m_chip = 0;
            present_chip();
         end
      end else if (!play_en) begin
         m_run  = 0;
         m_chip = 0;
         e_chip = 0;
         e_dac  = 0;
      end else if (m_held == m_hold) begin
         m_chip = (m_chip + 1) % CHIPS;
         present_chip();
      end else begin
         m_held++;
      end
   endtask

   initial begin : model
      model_reset();
      forever begin
         @(posedge rdclock or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model
   initial begin : compare
      forever begin
         @(negedge rdclock);
         check("chip",         chip,              e_chip);
         check("chip_strobe",  chip_strobe,       e_strobe);
         check("epoch",        epoch,             e_epoch);
         check("dac_data",     $signed(dac_data), e_dac);
         check("bank_valid",   bank_valid,        m_valid);
         check("swap_pending", swap_pending,      m_pend);
         check("load_err",     load_err,          e_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge rdclock);
   endtask

   task automatic burst(input int n, input logic [31:0] w0, input logic [31:0] rest, input bit rnd);
      for (int i = 0; i < n; i++) begin
         @(negedge rdclock);
         wr_en   = 1'b1;
         wr_data = rnd ? $urandom : ((i == 0) ? w0 : rest);
      end
      @(negedge rdclock);
      wr_en   = 1'b0;
      wr_data = '0;
   endtask

   task automatic wait_epoch(input string name, input int budget);
      bit found = 0;
      for (int i = 0; i < budget; i++) begin
         @(negedge rdclock);
         if (epoch) begin
            found = 1;
            break;
         end
      end
      check(name, found, 1);
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_chip"},  chip,         0);
      check({name, "_strb"},  chip_strobe,  0);
      check({name, "_epoch"}, epoch,        0);
      check({name, "_dac"},   dac_data,     0);
      check({name, "_valid"}, bank_valid,   0);
      check({name, "_pend"},  swap_pending, 0);
      check({name, "_err"},   load_err,     0);
   endtask

   task automatic expect_err(input string name);
      bit seen = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge rdclock);
         if (load_err) seen = 1;
      end
      check(name, seen, 1);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin : stim
      int lat, cnt, first_gap, nstrb, run_len, last_len, prev_dac;
      bit pend_ok, v0, p0;

      // Reset state
      idle(3);
      check_zero_outputs("reset");
      @(negedge rdclock);
      #2 rst_n = 1'b1;

      // Play request without a committed bank stays silent
      @(negedge rdclock);
      play_en   = 1'b1;
      amplitude = 13'd1000;
      chip_div  = '0;
      idle(5);
      check("nobank_dac", $signed(dac_data), 0);
      check("nobank_valid", bank_valid, 0);

      // word0 = 0x8000_0001, rest 0; commit immediately, play next cycle
      burst(32, 32'h8000_0001, 32'h0, 0);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge rdclock);
         lat++;
         if (epoch) break;
      end
      check("start_latency", lat, 3);
      check("c0_dac", $signed(dac_data), 1000);
      for (int k = 1; k <= 1024; k++) begin
         @(negedge rdclock);
         if (k == 1)    check("c1_dac",   $signed(dac_data), -1000);
         if (k == 30)   check("c30_dac",  $signed(dac_data), -1000);
         if (k == 31)   check("c31_dac",  $signed(dac_data), 1000);
         if (k == 32)   check("c32_dac",  $signed(dac_data), -1000);
         if (k == 1023) check("c1023_epoch", epoch, 0);
         if (k == 1024) begin
            check("wrap_epoch", epoch, 1);
            check("wrap_dac", $signed(dac_data), 1000);
         end
      end

      // chip_div = 3: 4-cycle chips, 4096-cycle epochs
      chip_div = 16'd3;
      wait_epoch("div3_first_epoch", 5000);
      cnt = 0; first_gap = 0; nstrb = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge rdclock);
         cnt++;
         if (chip_strobe) begin
            nstrb++;
            if (first_gap == 0) first_gap = cnt;
         end
         if (epoch) break;
      end
      check("div3_strobe_gap", first_gap, 4);
      check("div3_epoch_period", cnt, 4096);
      check("div3_strobes", nstrb, 1024);

      // Code A (all ones) then code B (all zeros) swapped at epoch boundaries
      chip_div  = 16'd2;
      amplitude = 13'd500;
      burst(32, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      idle(1);
      check("A_pending", swap_pending, 1);
      wait_epoch("A_epoch", 5000);
      check("A_first_dac", $signed(dac_data), 500);
      check("A_pending_clr", swap_pending, 0);
      idle(100);
      burst(32, 32'h0, 32'h0, 0);
      idle(1);
      check("B_pending", swap_pending, 1);
      pend_ok = 1; run_len = 0; last_len = 0; prev_dac = 0;
      cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge rdclock);
         if (chip_strobe) begin
            last_len = run_len;
            run_len  = 1;
         end else begin
            run_len++;
         end
         if (epoch) begin
            cnt = 1;
            break;
         end
         if (!swap_pending) pend_ok = 0;
         prev_dac = int'($signed(dac_data));
      end
      check("B_epoch_seen", cnt, 1);
      check("B_pending_held", pend_ok, 1);
      check("B_first_dac", $signed(dac_data), -500);
      check("A_last_dac", prev_dac, 500);
      check("A_last_hold", last_len, 3);
      check("B_pending_clr", swap_pending, 0);

      // Malformed bursts: 31, 33 and 1 word
      v0 = bank_valid; p0 = swap_pending;
      idle(10);
      burst(31, 0, 0, 1);
      expect_err("err_31");
      check("err_31_valid", bank_valid, v0);
      check("err_31_pend", swap_pending, p0);
      burst(33, 0, 0, 1);
      expect_err("err_33");
      check("err_33_valid", bank_valid, v0);
      check("err_33_pend", swap_pending, p0);
      burst(1, 0, 0, 1);
      expect_err("err_1");

      // Randomized traffic against the model
      for (int it = 0; it < 70; it++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: begin
               int n;
               n = 32;
               if ($urandom_range(0, 5) == 0) begin
                  case ($urandom_range(0, 2))
                     0: n = 31;
                     1: n = 33;
                     default: n = 1;
                  endcase
               end
               burst(n, 0, 0, 1);
            end
            4, 5: begin
               @(negedge rdclock);
               play_en = ($urandom_range(0, 3) != 0);
            end
            6: begin
               @(negedge rdclock);
               chip_div  = DIV_W'($urandom_range(0, 3));
               amplitude = (DAC_W-1)'($urandom);
            end
            default: idle($urandom_range(1, 400));
         endcase
      end

      // Reset in the middle of a burst
      play_en = 1'b0;
      idle(3);
      for (int i = 0; i < 10; i++) begin
         @(negedge rdclock);
         wr_en   = 1'b1;
         wr_data = $urandom;
      end
      #2 rst_n = 1'b0;
      wr_en = 1'b0;
      #1 check_zero_outputs("rst_load");
      @(negedge rdclock);
      #2 rst_n = 1'b1;
      idle(2);
      check("rst_load_valid", bank_valid, 0);

      // Reset in the middle of playback
      play_en  = 1'b1;
      chip_div = '0;
      burst(32, 0, 0, 1);
      idle(200);
      #2 rst_n = 1'b0;
      #1 check_zero_outputs("rst_play");
      @(negedge rdclock);
      #2 rst_n = 1'b1;
      idle(5);
      check("rst_play_valid", bank_valid, 0);
      check("rst_play_dac", $signed(dac_data), 0);
      burst(32, 32'h8000_0001, 32'h0, 0);
      wait_epoch("reload_epoch", 20);
      check("reload_dac", $signed(dac_data), 0 + int'(amplitude));
      idle(50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global bound on run time
   initial begin : watchdog
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
